// File: rtl/iter_multdiv_unit.sv
// Iterative signed multiply/divide unit with start/ack handshake, flush and exception reporting.
// Optional MULTDIV_EARLY_DONE_EN: multiply finishes once the remaining multiplier bits are zero.
module iter_multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             result_ack,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               dvz_q, dvz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               load;
    logic               last_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_acc_nxt, prod;
    logic [WIDTH:0]     rem_shift, rem_diff, rem_nxt;
    logic [WIDTH-1:0]   quo_nxt, quo_signed;

    assign mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign ready        = (state_q != StRun);
    assign busy         = (state_q == StRun);
    assign result_valid = (state_q == StDone);
    assign result       = result_q;
    assign exception    = exc_q;

    assign load      = ready && start;
    assign last_step = (cnt_q == CNT_W'(1));

`ifdef MULTDIV_EARLY_DONE_EN
    assign mul_done = last_step || (mplier_q[WIDTH-1:1] == '0);
`else
    assign mul_done = last_step;
`endif

    // Multiply datapath: shift-add of magnitudes, sign applied on the final step
    assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod        = neg_q ? -mul_acc_nxt : mul_acc_nxt;

    // Divide datapath: restoring step, remainder kept in the low bits of acc_q
    assign rem_shift  = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    assign rem_diff   = rem_shift - {1'b0, mcand_q[WIDTH-1:0]};
    assign rem_nxt    = rem_diff[WIDTH] ? rem_shift : rem_diff;
    assign quo_nxt    = {mplier_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    assign quo_signed = neg_q ? -quo_nxt : quo_nxt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        dvz_d    = dvz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            StRun: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q) begin
                    acc_d    = {{(WIDTH-1){1'b0}}, rem_nxt};
                    mplier_d = quo_nxt;
                    if (dvz_q) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (last_step) begin
                        state_d  = StDone;
                        result_d = quo_signed;
                        exc_d    = ovf_q;
                    end
                end else begin
                    acc_d    = mul_acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (mul_done) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        result_d = prod[WIDTH-1:0];
                        exc_d    = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
                    end
                end
            end
            StDone: begin
                if (!start && result_ack) state_d = StIdle;
            end
            StIdle: ;
            default: state_d = StIdle;
        endcase

        // Accept from IDLE or DONE; start outranks ack in DONE
        if (load) begin
            state_d  = StRun;
            cnt_d    = CNT_W'(WIDTH);
            op_d     = op;
            neg_d    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            ovf_d    = op && (operand_a == MinVal) && (operand_b == {WIDTH{1'b1}});
            dvz_d    = op && (operand_b == '0);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, (op ? mag_b : mag_a)};
            mplier_d = op ? mag_a : mag_b;
        end

        if (flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = '0;
            exc_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dvz_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            dvz_q    <= dvz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: tb/tb_iter_multdiv_unit.sv
// Directed self-checking bench for iter_multdiv_unit (WIDTH=32).
module tb_iter_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        result_ack;
    logic        ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        exception;

    int checks   = 0;
    int failures = 0;

    iter_multdiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .result_ack  (result_ack),
        .ready       (ready),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .exception   (exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive a request for one edge (E0); returns just after E0
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        step();
        start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    endtask

    // Edges after E0 until result_valid; also flags busy dropping before that
    task automatic wait_valid(output int lat, output bit busy_gap);
        lat = 0;
        busy_gap = 1'b0;
        do begin
            if (!busy) busy_gap = 1'b1;
            step();
            lat++;
        end while (!result_valid && lat < 100);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_exc, input int exp_lat);
        int lat;
        bit gap;
        issue(o, a, b);
        wait_valid(lat, gap);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(gap), 64'(0));
        chk({tag, "_res"}, 64'(result), 64'(exp_res));
        chk({tag, "_exc"}, 64'(exception), 64'(exp_exc));
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk({tag, "_ack_ready"}, 64'({ready, result_valid, busy}), 64'(3'b100));
    endtask

    initial begin
        int lat;
        bit gap;
        reset = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        flush = 1'b0; result_ack = 1'b0;
        #2 reset = 1'b0;
        step();
        step();
        chk("reset_state", 64'({ready, busy, result_valid, exception, result}),
            64'({4'b1000, 32'h0}));
        reset = 1'b1;
        step();

        // Basic multiply and divide vectors
        issue(1'b0, 32'd7, 32'hFFFF_FFFA);
        chk("mul7_busy_e0", 64'({busy, ready}), 64'(2'b10));
        wait_valid(lat, gap);
        chk("mul7_lat", 64'(lat), 64'(32));
        chk("mul7_busy", 64'(gap), 64'(0));
        chk("mul7_res", 64'(result), 64'(32'hFFFF_FFD6));
        chk("mul7_flags", 64'({exception, busy, ready}), 64'(3'b001));
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("mul7_ack", 64'({ready, result_valid}), 64'(2'b10));

        run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 32);
        run_op("mul_min", 1'b0, 32'h8000_0000, 32'h1, 32'h8000_0000, 1'b0, 32);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 32);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32);
        run_op("div_by0", 1'b1, 32'd5, 32'd0, 32'h0, 1'b1, 1);
        run_op("div_minm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32);

        // start hammered during RUN is ignored
        issue(1'b0, 32'd3, 32'd5);
        start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd7;
        repeat (20) step();
        start = 1'b0;
        wait_valid(lat, gap);
        chk("ign_lat", 64'(lat + 20), 64'(32));
        chk("ign_res", 64'(result), 64'(15));
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        repeat (3) step();
        chk("ign_one_result", 64'({result_valid, busy}), 64'(2'b00));

        // start in DONE launches a new op
        issue(1'b0, 32'd3, 32'd5);
        wait_valid(lat, gap);
        chk("done_first", 64'(result), 64'(15));
        issue(1'b1, 32'd100, 32'd7);
        chk("done_restart", 64'({result_valid, busy}), 64'(2'b01));
        wait_valid(lat, gap);
        chk("done_restart_lat", 64'(lat), 64'(32));
        chk("done_restart_res", 64'(result), 64'(14));

        // start and ack together in DONE: start wins
        result_ack = 1'b1;
        issue(1'b1, 32'd20, 32'hFFFF_FFFD);
        result_ack = 1'b0;
        chk("start_ack_busy", 64'({result_valid, busy}), 64'(2'b01));
        wait_valid(lat, gap);
        chk("start_ack_res", 64'({exception, result}), 64'({1'b0, 32'hFFFF_FFFA}));

        // Flush mid-multiply (held result is also cleared)
        issue(1'b0, 32'd11, 32'd13);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_state", 64'({busy, result_valid, ready, exception, result}),
            64'({4'b0010, 32'h0}));
        repeat (40) step();
        chk("flush_no_result", 64'({busy, result_valid}), 64'(2'b00));

        // Flush with start in IDLE
        flush = 1'b1;
        issue(1'b0, 32'd2, 32'd2);
        flush = 1'b0;
        chk("flush_start", 64'({busy, ready}), 64'(2'b01));
        step();
        chk("flush_start_idle", 64'({busy, result_valid}), 64'(2'b00));

        // Async reset mid-divide
        issue(1'b1, 32'd100, 32'd7);
        wait_valid(lat, gap);
        chk("pre_rst_res", 64'(result), 64'(14));
        issue(1'b1, 32'd50, 32'd5);
        repeat (5) step();
        reset = 1'b0;
        #1;
        chk("rst_mid", 64'({busy, result_valid, ready, exception, result}),
            64'({4'b0010, 32'h0}));
        step();
        reset = 1'b1;
        step();

        // Early completion (or full latency when the feature is absent)
`ifdef MULTDIV_EARLY_DONE_EN
        run_op("mul_123x4", 1'b0, 32'd123, 32'd4, 32'd492, 1'b0, 3);
        run_op("mul_9x0", 1'b0, 32'd9, 32'd0, 32'd0, 1'b0, 1);
`else
        run_op("mul_123x4", 1'b0, 32'd123, 32'd4, 32'd492, 1'b0, 32);
        run_op("mul_9x0", 1'b0, 32'd9, 32'd0, 32'd0, 1'b0, 32);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
